// File: rtl/data_memory_ext_if.sv
// Request/response bundle for data_memory_ext: request fields from the
// master, and ready/valid/data/error back from the memory.
interface data_memory_ext_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              REQ;
    logic              WE;
    logic [1:0]        SIZE;
    logic              UNS;
    logic [ADDR_W-1:0] A;
    logic [31:0]       WD;
    logic              READY;
    logic              RVALID;
    logic [31:0]       RD;
    logic              ERR;

    modport master (
        output REQ, WE, SIZE, UNS, A, WD,
        input  READY, RVALID, RD, ERR
    );

    modport slave (
        input  REQ, WE, SIZE, UNS, A, WD,
        output READY, RVALID, RD, ERR
    );
endinterface

// File: rtl/data_memory_ext.sv
// Byte-addressed little-endian data memory with sub-word loads/stores,
// sign/zero extension, alignment checking and a programmable read latency.
module data_memory_ext #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned RD_LAT  = 1,
    parameter int unsigned PRELOAD = 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    data_memory_ext_if.slave  bus
);

    localparam int unsigned IDX_W = ADDR_W - 2;
    localparam int unsigned DEPTH = 2 ** IDX_W;
    localparam int unsigned CNT_W = 2;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    typedef logic [31:0] mem_t [DEPTH];

    // Power-up image: words 0..9 hold 10, 20, ... 100 when PRELOAD is set.
    function automatic mem_t init_mem();
        mem_t m;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (PRELOAD != 0 && i < 10) m[i] = 32'((i + 1) * 10);
            else                        m[i] = 32'h0;
        end
        return m;
    endfunction

    mem_t mem_q = init_mem();

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rvalid_q, rvalid_d;
    logic               err_q, err_d;
    logic [31:0]        rd_q, rd_d;
    logic [31:0]        pend_q, pend_d;

    logic [IDX_W-1:0]   idx_c;
    logic [1:0]         lane_c;
    logic               illegal_c;
    logic               accept_c;
    logic               store_c;
    logic [31:0]        word_c;
    logic [7:0]         byte_c;
    logic [15:0]        half_c;
    logic [31:0]        load_c;
    logic [31:0]        wdata_c;
    logic [3:0]         be_c;

    // Request decode and alignment check
    always_comb begin
        idx_c     = bus.A[ADDR_W-1:2];
        lane_c    = bus.A[1:0];
        illegal_c = (bus.SIZE == 2'b11)
                  || (bus.SIZE == 2'b01 && lane_c[0])
                  || (bus.SIZE == 2'b10 && lane_c != 2'b00);
        accept_c  = bus.REQ && (state_q == S_IDLE);
        store_c   = accept_c && bus.WE && !illegal_c;
    end

    // Load extraction: right-justify the addressed lane(s), then extend
    always_comb begin
        word_c = mem_q[idx_c];
        byte_c = word_c[{lane_c, 3'b000} +: 8];
        half_c = lane_c[1] ? word_c[31:16] : word_c[15:0];
        load_c = word_c;
        case (bus.SIZE)
            2'b00:   load_c = bus.UNS ? {24'h0, byte_c} : {{24{byte_c[7]}}, byte_c};
            2'b01:   load_c = bus.UNS ? {16'h0, half_c} : {{16{half_c[15]}}, half_c};
            default: load_c = word_c;
        endcase
    end

    // Store lane enables with the write data replicated across lanes
    always_comb begin
        be_c    = 4'b0000;
        wdata_c = bus.WD;
        case (bus.SIZE)
            2'b00: begin
                be_c    = 4'(4'b0001 << lane_c);
                wdata_c = {4{bus.WD[7:0]}};
            end
            2'b01: begin
                be_c    = lane_c[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{bus.WD[15:0]}};
            end
            2'b10: begin
                be_c    = 4'b1111;
                wdata_c = bus.WD;
            end
            default: begin
                be_c    = 4'b0000;
                wdata_c = bus.WD;
            end
        endcase
    end

    // Array has no reset so contents survive RST_N
    always_ff @(posedge CLK) begin
        if (store_c) begin
            for (int n = 0; n < 4; n++) begin
                if (be_c[n]) mem_q[idx_c][8*n +: 8] <= wdata_c[8*n +: 8];
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rd_q     <= 32'h0;
            pend_q   <= 32'h0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rd_q     <= rd_d;
            pend_q   <= pend_d;
        end
    end

    // Next state: single-cycle loads complete straight from IDLE; longer
    // latencies park the extended data in pend_q and count down in BUSY.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rvalid_d = 1'b0;
        err_d    = 1'b0;
        rd_d     = rd_q;
        pend_d   = pend_q;
        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    if (illegal_c) begin
                        err_d = 1'b1;
                    end else if (!bus.WE) begin
                        if (RD_LAT <= 1) begin
                            rd_d     = load_c;
                            rvalid_d = 1'b1;
                        end else begin
                            pend_d  = load_c;
                            cnt_d   = CNT_W'(RD_LAT - 1);
                            state_d = S_BUSY;
                        end
                    end
                end
            end
            S_BUSY: begin
                if (cnt_q <= CNT_W'(1)) begin
                    rd_d     = pend_q;
                    rvalid_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
        endcase
    end

    assign bus.READY  = (state_q == S_IDLE);
    assign bus.RVALID = rvalid_q;
    assign bus.ERR    = err_q;
    assign bus.RD     = rd_q;

endmodule

// File: doc/data_memory_ext.md
DATA_MEMORY_EXT -- requirements
Module: data_memory_ext

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with the clock port named CLK and the reset port named RST_N.
REQ-002 Parameter ADDR_W, default 8: byte-address width; the array SHALL hold 2**(ADDR_W-2) 32-bit words.
REQ-003 Parameter RD_LAT, default 1: read latency in cycles; legal values are 1 to 4.
REQ-004 Parameter PRELOAD, default 1: when 1, word i (i = 0..9) SHALL initialise to (i+1)*10 at time zero; all other words are undefined.
REQ-005 CLK  input  1  clock; all state changes occur on the rising edge.
REQ-006 RST_N  input  1  asynchronous active-low reset.
REQ-007 REQ  input  1  request valid.
REQ-008 WE  input  1  1 = store, 0 = load; sampled with REQ.
REQ-009 SIZE  input  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
REQ-010 UNS  input  1  1 = zero-extend sub-word loads, 0 = sign-extend.
REQ-011 A  input  ADDR_W  byte address.
REQ-012 WD  input  32  store data; sub-word stores use the low bits.
REQ-013 READY  output  1  block can accept a request this cycle.
REQ-014 RVALID  output  1  one-cycle pulse; RD is valid.
REQ-015 RD  output  32  load data, extended per SIZE and UNS.
REQ-016 ERR  output  1  one-cycle pulse flagging a misaligned or illegal request.

Function
REQ-017 A request SHALL be accepted on a rising edge where REQ=1 and READY=1; inputs are ignored otherwise.
REQ-018 The FSM SHALL have two states: IDLE (READY=1) and BUSY (READY=0).
REQ-019 Memory layout SHALL be little-endian: byte lane n of word A[ADDR_W-1:2] holds byte address A[1:0]=n.
REQ-020 Error condition: SIZE=11, or SIZE=01 with A[0]=1, or SIZE=10 with A[1:0]!=00.
REQ-021 On an errored request: no memory change; RVALID stays 0; ERR=1 for the cycle after acceptance; FSM stays IDLE.
REQ-022 Legal store: write only the addressed lanes (1, 2 or 4) on the acceptance edge; other lanes unchanged; FSM stays IDLE; no RVALID.
REQ-023 Legal load on acceptance edge k: FSM SHALL enter BUSY and load a latency counter.
REQ-024 RVALID SHALL be 1 for exactly the single cycle following edge k+RD_LAT-1, with RD updated at that edge.
REQ-025 The FSM SHALL return to IDLE in the RVALID cycle, so READY=1 concurrently with RVALID and back-to-back loads sustain one load per RD_LAT cycles.
REQ-026 Load data SHALL be the memory contents at the acceptance edge; a store accepted before a load is visible to that load.
REQ-027 Loads SHALL right-justify the selected byte or half and extend bit 7 or bit 15 when UNS=0; UNS is ignored for word loads.
REQ-028 RD SHALL hold its last loaded value until the next RVALID; it does not change on stores or errors.
REQ-029 Address wrap: A is exactly ADDR_W bits wide; there is no out-of-range condition.

Reset
REQ-030 RST_N=0 SHALL asynchronously force FSM=IDLE, latency counter=0, READY=1 (after release), RVALID=0, ERR=0, RD=0.
REQ-031 Reset SHALL NOT alter array contents.
REQ-032 Reset during BUSY SHALL abort the pending load: no RVALID is issued after release.

Verification
REQ-033 PRELOAD=1, RD_LAT=1: after reset, load word A=0x24 -> RVALID next cycle, RD=100; READY low for 0 cycles of idle gap.
REQ-034 Store word 0x80FF7F01 at A=0x00; load byte A=0x01 UNS=0 -> RD=0x0000007F; load byte A=0x03 UNS=0 -> 0xFFFFFF80; load half A=0x02 UNS=1 -> 0x000080FF.
REQ-035 Store byte 0xAB at A=0x05 over preloaded word 20 -> load word A=0x04 returns 0x0000AB14.
REQ-036 Half load at A=0x03, word store at A=0x06, and SIZE=11 -> ERR pulses once each; RVALID=0; memory and RD unchanged.
REQ-037 RD_LAT=3: loads issued whenever READY=1 -> RVALID pulses every 3 cycles, READY=0 for 2 cycles after each acceptance.
REQ-038 RD_LAT=3: assert RST_N=0 one cycle after load acceptance -> RVALID never asserts; the next load after release behaves normally and returns unchanged array data.
